// File: rtl/ddr_ahb_csr_master.sv
// ddr_ahb_csr_master
// Single-outstanding AHB-Lite master. It converts valid/ready register requests
// into single-word AHB transfers and returns read data and error status on a
// valid/ready response channel. A data-phase timeout keeps a stuck slave from
// hanging the requester. Only one transfer is in flight at a time, so the
// address phase of a transfer never overlaps the data phase of another.
module ddr_ahb_csr_master #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              i_hclk,
  input  logic              i_hreset,
  // request channel
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  // response channel
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DWIDTH-1:0] o_rsp_rdata,
  output logic              o_rsp_error,
  output logic              o_rsp_timeout,
  // AHB-Lite master side
  output logic [AWIDTH-1:0] o_haddr,
  output logic              o_hwrite,
  output logic              o_hsel,
  output logic [DWIDTH-1:0] o_hwdata,
  output logic [1:0]        o_htrans,
  output logic [2:0]        o_hsize,
  output logic [2:0]        o_hburst,
  output logic              o_hreadyin,
  input  logic              i_hready,
  input  logic [DWIDTH-1:0] i_hrdata,
  input  logic [1:0]        i_hresp
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_RESP = 2'b11
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic          w_misaligned;
  logic          w_slave_err;

  // Word transfers only: any nonzero low address bit is rejected locally.
  assign w_misaligned = (i_req_addr[1:0] != 2'b00);
  assign w_slave_err  = (i_hresp != 2'b00);

  // Fixed transfer attributes; hreadyin simply mirrors the slave's hready.
  assign o_hsize    = 3'b010;
  assign o_hburst   = 3'b000;
  assign o_hreadyin = i_hready;

  // Transfer FSM with all handshake and bus outputs registered alongside it.
  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      o_req_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_error   <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_haddr       <= '0;
      o_hwrite      <= 1'b0;
      o_hsel        <= 1'b0;
      o_hwdata      <= '0;
      o_htrans      <= HTRANS_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            // Capture the request; hwdata is loaded now so it is already
            // stable by the time the data phase starts.
            o_req_ready <= 1'b0;
            o_haddr     <= i_req_addr;
            o_hwrite    <= i_req_write;
            o_hwdata    <= i_req_wdata;
            if (w_misaligned) begin
              // Answer immediately without touching the bus.
              r_state       <= S_RESP;
              o_rsp_valid   <= 1'b1;
              o_rsp_error   <= 1'b1;
              o_rsp_timeout <= 1'b0;
              o_rsp_rdata   <= '0;
            end else begin
              r_state  <= S_ADDR;
              o_hsel   <= 1'b1;
              o_htrans <= HTRANS_NONSEQ;
            end
          end
        end

        S_ADDR: begin
          // Address phase completes on the first cycle the bus is ready.
          if (i_hready) begin
            r_state  <= S_DATA;
            o_hsel   <= 1'b0;
            o_htrans <= HTRANS_IDLE;
            r_cnt    <= '0;
          end
        end

        S_DATA: begin
          if (i_hready) begin
            // Completion; read data is only meaningful for good reads.
            r_state       <= S_RESP;
            r_cnt         <= '0;
            o_rsp_valid   <= 1'b1;
            o_rsp_error   <= w_slave_err;
            o_rsp_timeout <= 1'b0;
            o_rsp_rdata   <= (o_hwrite || w_slave_err) ? '0 : i_hrdata;
          end else if (r_cnt == CNT_MAX) begin
            // Slave has stalled for too long: abandon the transfer.
            r_state       <= S_RESP;
            r_cnt         <= '0;
            o_rsp_valid   <= 1'b1;
            o_rsp_error   <= 1'b1;
            o_rsp_timeout <= 1'b1;
            o_rsp_rdata   <= '0;
          end else begin
            // Wait state, including the first cycle of a two-cycle ERROR.
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_RESP: begin
          // Payload is held until the consumer takes it.
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_hsel      <= 1'b0;
          o_htrans    <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule
